// File: rtl/fan_command_scheduler.sv
// fan_command_scheduler: accepts one fan command per valid/ready handshake and
// issues REPEAT_COUNT start pulses to the packet generator. Each start reserves
// a PACKET_CYCLES window followed by a GAP_CYCLES idle RF gap. Abort requests
// let the current packet window finish, except in a gap, where they end the
// command at once.
module fan_command_scheduler #(
  parameter int unsigned REPEAT_COUNT  = 6,
  parameter int unsigned PACKET_CYCLES = 88120,
  parameter int unsigned GAP_CYCLES    = 22030,
  parameter int unsigned CTR_WIDTH     = 18
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_cmd,
  output logic       req_ready,
  input  logic       abort,
  output logic [2:0] cmd,
  output logic       start,
  output logic       busy,
  output logic       done,
  output logic       rejected
);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  localparam logic [CTR_WIDTH-1:0] PKT_LOAD = CTR_WIDTH'(PACKET_CYCLES - 1);
  localparam logic [CTR_WIDTH-1:0] GAP_LOAD = CTR_WIDTH'(GAP_CYCLES - 1);
  localparam logic [7:0]           REP_LOAD = 8'(REPEAT_COUNT - 1);

  state_t               state;
  logic [CTR_WIDTH-1:0] counter;
  logic [7:0]           repeats_left;
  logic                 abort_pending;

  // A request can only be taken while no command is in progress.
  always_comb begin
    req_ready = (state == IDLE);
  end

  // Command sequencer. Outputs are registered, so start is raised on the edge
  // that enters START rather than decoded from the state.
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= '0;
      repeats_left  <= '0;
      abort_pending <= 1'b0;
      cmd           <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rejected      <= 1'b0;
    end else begin
      start    <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
      case (state)
        IDLE: begin
          abort_pending <= 1'b0;
          if (req_valid) begin
            if (req_cmd <= 3'd4) begin
              cmd          <= req_cmd;
              repeats_left <= REP_LOAD;
              state        <= START;
              start        <= 1'b1;
              busy         <= 1'b1;
            end else begin
              rejected <= 1'b1;
            end
          end
        end
        START: begin
          counter <= PKT_LOAD;
          state   <= SEND;
          if (abort) abort_pending <= 1'b1;
        end
        SEND: begin
          if (counter == '0) begin
            // An abort on the last window cycle still counts as pending.
            if (repeats_left == '0 || abort_pending || abort) begin
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              abort_pending <= 1'b0;
            end else begin
              repeats_left <= repeats_left - 8'd1;
              counter      <= GAP_LOAD;
              state        <= GAP;
            end
          end else begin
            counter <= counter - CTR_WIDTH'(1);
            if (abort) abort_pending <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b1;
            abort_pending <= 1'b0;
          end else if (counter == '0) begin
            state <= START;
            start <= 1'b1;
          end else begin
            counter <= counter - CTR_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fan_command_scheduler.md
Name: fan_command_scheduler

Overview:
- Sits directly upstream of the fan packet generator and drives its cmd and start inputs.
- Accepts one fan command per valid/ready handshake, latches it, and issues REPEAT_COUNT start pulses to the generator.
- Start pulses are spaced so each packet finishes and is followed by an idle RF gap, because a receiver needs repeated transmissions.
- Reports busy, per-command completion and rejection of unsupported codes.

Parameters:
- REPEAT_COUNT, 6, number of packets sent per accepted command; must be 1..255.
- PACKET_CYCLES, 88120, ref_clk cycles reserved for one packet after its start pulse (40 symbol phases x 2203); must be >=1.
- GAP_CYCLES, 22030, idle ref_clk cycles between the end of one packet window and the next start pulse; must be >=1.
- CTR_WIDTH, 18, width of the timing counter; must hold max(PACKET_CYCLES, GAP_CYCLES).

Ports:
- ref_clk  input  1  sole clock; everything is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  requester presents a command.
- req_cmd  input  3  command code; 0..4 are valid, 5..7 are unsupported.
- req_ready  output  1  block can accept a command this cycle.
- abort  input  1  synchronous request to end the current command early.
- cmd  output  3  command code to the generator; held stable while busy and after completion.
- start  output  1  one-cycle start pulse to the generator.
- busy  output  1  a command is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a command finishes or is aborted.
- rejected  output  1  one-cycle pulse when an unsupported code is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cmd=0, start=0, busy=0, done=0, rejected=0.
  - Counters cleared; req_ready=1 immediately.
  - Reset mid-command drops the command with no done pulse.
- All outputs except req_ready are registered. req_ready = (state==IDLE), combinational.
- Handshake: a transfer occurs on a rising edge where req_valid=1 and req_ready=1. req_cmd is sampled at that edge.
- States: IDLE, START, SEND, GAP.
- IDLE:
  - On a transfer with req_cmd<=4: latch cmd, set repeats_left=REPEAT_COUNT-1, go to START.
  - On a transfer with req_cmd>=5: stay in IDLE, pulse rejected for one cycle; cmd is unchanged and no start is issued.
- START (exactly one cycle):
  - start=1, busy=1. The start pulse appears on the cycle after the handshake edge.
  - Load counter=PACKET_CYCLES-1, go to SEND.
- SEND:
  - Decrement counter each cycle.
  - At counter==0: if repeats_left==0 or an abort is pending, go to IDLE and assert done that cycle. Otherwise decrement repeats_left, load counter=GAP_CYCLES-1 and go to GAP.
- GAP:
  - Decrement counter each cycle; at 0 go to START.
  - abort=1 in GAP goes to IDLE immediately and pulses done.
- Abort:
  - abort=1 in START or SEND sets a pending flag. The current packet window always completes, because the generator cannot be cut mid-packet. Then the command ends as above.
  - abort in IDLE is ignored. The pending flag clears on entering IDLE.
- Timing:
  - Consecutive start pulses are exactly 1+PACKET_CYCLES+GAP_CYCLES cycles apart.
  - done appears PACKET_CYCLES+1 cycles after the final start pulse.
  - A command takes REPEAT_COUNT*(1+PACKET_CYCLES)+(REPEAT_COUNT-1)*GAP_CYCLES cycles from the first start to done.
- In the done cycle state is already IDLE and req_ready=1, so a back-to-back request is accepted at that edge. Its start follows one cycle later.
- req_valid while busy is stalled, not dropped; the requester holds it.
- cmd changes only on an accepted valid command.

Test Plan (sim with PACKET_CYCLES=10, GAP_CYCLES=4, REPEAT_COUNT=3):
- Reset, then req_valid=1, req_cmd=2 for one cycle (handshake at edge T) -> start high at T+1, T+16, T+31; cmd=2 throughout; done at T+42; busy high T+1..T+41; req_ready low T+1..T+41.
- req_cmd=6 with req_valid=1 in IDLE -> rejected pulse the next cycle, no start, busy stays 0, cmd keeps its previous value.
- Command 1 in progress; hold req_valid=1, req_cmd=4 -> not accepted until the done cycle; the first start for cmd=4 comes one cycle after done; exactly 3 starts per command.
- abort=1 for one cycle during the first GAP -> state IDLE with done the next cycle; no further start; total starts=1.
- abort=1 during the second SEND -> that packet window completes (10 cycles), then done; no third start.
- Assert reset low mid-SEND of command 3 -> outputs cleared immediately, no done pulse; after release, a new command 0 runs normally with 3 starts.
